// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: turns load/store controls into a byte-enabled req/gnt/rvalid bus access.
// Latency: stalls at least 2 cycles (grant in the issue cycle, rvalid one cycle later); result presented in DONE.
// Backpressure: stallM_o holds the pipeline while the bus has not granted or responded; a timeout aborts the access.
//
// Ports:
//   clk_i, rst_i           clock (rising edge), asynchronous active-low reset
//   memreadM_i/memwriteM_i load / store request from EX/MEM
//   funct3M_i              access size and sign (instr[14:12])
//   aluresultM_i           effective byte address
//   writedataM_i           store data (rs2)
//   readdataM_o            formatted load data for MEM/WB (non-zero only in DONE)
//   stallM_o               freeze the front of the pipeline and hold MEM/WB input
//   access_err_o           one-cycle pulse on a misaligned or illegal access
//   bus_err_o              sticky bus-timeout flag
//   mem_*                  data-memory bus (req/gnt handshake, rvalid response)
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        memreadM_i,
    input  logic        memwriteM_i,
    input  logic [2:0]  funct3M_i,
    input  logic [31:0] aluresultM_i,
    input  logic [31:0] writedataM_i,
    output logic [31:0] readdataM_o,
    output logic        stallM_o,
    output logic        access_err_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    // Abort fires on the cycle whose incremented count reaches this value.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] load_q, load_d;
    logic        bus_err_q, bus_err_d;

    // Decode
    logic        is_ld, is_st, mem_op;
    logic        f3_legal, aligned, acc_vld;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;
    logic [7:0]  cnt_inc;
    logic        timeout;

    // Unmasked FSM outputs, forced to zero while reset is asserted
    logic        req_c, stall_c, err_c;
    logic [31:0] rd_c;

    always_comb begin
        is_ld  = memreadM_i & ~memwriteM_i;
        is_st  = memwriteM_i & ~memreadM_i;
        mem_op = memreadM_i | memwriteM_i;

        f3_legal = 1'b0;
        if (is_ld) begin
            case (funct3M_i)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                default:                                f3_legal = 1'b0;
            endcase
        end else if (is_st) begin
            case (funct3M_i)
                3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
                default:                f3_legal = 1'b0;
            endcase
        end

        case (funct3M_i[1:0])
            2'b01:   aligned = ~aluresultM_i[0];
            2'b10:   aligned = (aluresultM_i[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase

        acc_vld = (is_ld | is_st) & f3_legal & aligned;
    end

    // Byte enables and lane-replicated store data
    always_comb begin
        be_c    = 4'b0000;
        wdata_c = writedataM_i;
        case (funct3M_i[1:0])
            2'b00: begin
                be_c    = 4'b0001 << aluresultM_i[1:0];
                wdata_c = {4{writedataM_i[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << {aluresultM_i[1], 1'b0};
                wdata_c = {2{writedataM_i[15:0]}};
            end
            2'b10: begin
                be_c    = 4'b1111;
                wdata_c = writedataM_i;
            end
            default: begin
                be_c    = 4'b0000;
                wdata_c = writedataM_i;
            end
        endcase
    end

    // Load lane select and sign/zero extension
    always_comb begin
        case (aluresultM_i[1:0])
            2'b00:   ld_byte = mem_rdata_i[7:0];
            2'b01:   ld_byte = mem_rdata_i[15:8];
            2'b10:   ld_byte = mem_rdata_i[23:16];
            default: ld_byte = mem_rdata_i[31:24];
        endcase
        ld_half = aluresultM_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

        case (funct3M_i)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_fmt = mem_rdata_i;
            3'b100:  ld_fmt = {24'd0, ld_byte};
            3'b101:  ld_fmt = {16'd0, ld_half};
            default: ld_fmt = 32'd0;
        endcase
    end

    // FSM next-state and outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_d    = load_q;
        bus_err_d = bus_err_q;
        req_c     = 1'b0;
        stall_c   = 1'b0;
        err_c     = 1'b0;
        rd_c      = 32'd0;
        cnt_inc   = cnt_q + 8'd1;
        timeout   = (cnt_inc == TO_LAST);

        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (acc_vld) begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    state_d = mem_gnt_i ? S_WAIT : S_REQ;
                end else if (mem_op) begin
                    // Bad access: flag it and let the pipeline move on.
                    err_c = 1'b1;
                end
            end
            S_REQ: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                cnt_d   = cnt_inc;
                // A grant is not a completion, so the timeout still wins here.
                // Any rvalid seen in REQ is ignored: responses only follow a grant.
                if (timeout) begin
                    bus_err_d = 1'b1;
                    load_d    = 32'd0;
                    state_d   = S_DONE;
                end else if (mem_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_inc;
                if (mem_rvalid_i) begin
                    load_d  = is_ld ? ld_fmt : 32'd0;
                    state_d = S_DONE;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    load_d    = 32'd0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                rd_c    = load_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            load_q    <= 32'd0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            load_q    <= load_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Outputs drop the moment reset asserts, even mid-access, so the bus
    // never sees a request from a pipeline that is being reset.
    always_comb begin
        readdataM_o  = rd_c;
        stallM_o     = stall_c;
        access_err_o = err_c;
        bus_err_o    = bus_err_q;
        mem_req_o    = req_c;
        mem_we_o     = is_st;
        mem_addr_o   = {aluresultM_i[31:2], 2'b00};
        mem_be_o     = be_c;
        mem_wdata_o  = wdata_c;
        if (!rst_i) begin
            readdataM_o  = 32'd0;
            stallM_o     = 1'b0;
            access_err_o = 1'b0;
            bus_err_o    = 1'b0;
            mem_req_o    = 1'b0;
            mem_we_o     = 1'b0;
            mem_addr_o   = 32'd0;
            mem_be_o     = 4'd0;
            mem_wdata_o  = 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with hand-computed expectations.
// Inputs are driven 1 ns after the rising edge; outputs sampled on the falling edge.
// Bus responses are scripted per access; every wait loop is cycle-bounded.
module tb_mem_access_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        memreadM_i, memwriteM_i;
    logic [2:0]  funct3M_i;
    logic [31:0] aluresultM_i, writedataM_i;
    logic [31:0] readdataM_o;
    logic        stallM_o, access_err_o, bus_err_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    always #5 clk_i = ~clk_i;

    mem_access_stage #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .memreadM_i   (memreadM_i),
        .memwriteM_i  (memwriteM_i),
        .funct3M_i    (funct3M_i),
        .aluresultM_i (aluresultM_i),
        .writedataM_i (writedataM_i),
        .readdataM_o  (readdataM_o),
        .stallM_o     (stallM_o),
        .access_err_o (access_err_o),
        .bus_err_o    (bus_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        memreadM_i   = 1'b0;
        memwriteM_i  = 1'b0;
        funct3M_i    = 3'b000;
        aluresultM_i = 32'd0;
        writedataM_i = 32'd0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'd0;
    endtask

    // One complete access: grant after gnt_delay cycles, rvalid one cycle after grant.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int gnt_delay, input logic [31:0] rdata,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_rd);
        int req_cycles = 0;
        @(posedge clk_i); #1;
        memreadM_i   = rd;
        memwriteM_i  = wr;
        funct3M_i    = f3;
        aluresultM_i = addr;
        writedataM_i = wd;
        for (int c = 0; c <= gnt_delay; c++) begin
            mem_gnt_i = (c == gnt_delay);
            @(negedge clk_i);
            if (mem_req_o) req_cycles++;
            chk("req_stall", 32'(stallM_o), 32'd1);
            if (c == 0) begin
                chk("be", 32'(mem_be_o), 32'(exp_be));
                chk("wdata", mem_wdata_o, exp_wdata);
                chk("addr", mem_addr_o, {addr[31:2], 2'b00});
                chk("we", 32'(mem_we_o), 32'(wr));
            end
            @(posedge clk_i); #1;
        end
        chk("req_cycles", 32'(req_cycles), 32'(gnt_delay + 1));
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rdata;
        @(negedge clk_i);
        chk("wait_req", 32'(mem_req_o), 32'd0);
        chk("wait_stall", 32'(stallM_o), 32'd1);
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'd0;
        @(negedge clk_i);
        chk("done_stall", 32'(stallM_o), 32'd0);
        chk("done_rdata", readdataM_o, exp_rd);
        @(posedge clk_i); #1;
        idle_inputs();
        @(negedge clk_i);
        chk("idle_rdata", readdataM_o, 32'd0);
        chk("idle_stall", 32'(stallM_o), 32'd0);
    endtask

    task automatic err_case(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr);
        @(posedge clk_i); #1;
        memreadM_i   = rd;
        memwriteM_i  = wr;
        funct3M_i    = f3;
        aluresultM_i = addr;
        mem_gnt_i    = 1'b1;
        @(negedge clk_i);
        chk("err_pulse", 32'(access_err_o), 32'd1);
        chk("err_req", 32'(mem_req_o), 32'd0);
        chk("err_stall", 32'(stallM_o), 32'd0);
        chk("err_rdata", readdataM_o, 32'd0);
        @(posedge clk_i); #1;
        idle_inputs();
        @(negedge clk_i);
        chk("err_clear", 32'(access_err_o), 32'd0);
    endtask

    initial begin
        int n;
        idle_inputs();
        rst_i = 1'b0;
        // A valid-looking load during reset must not reach the bus.
        memreadM_i   = 1'b1;
        funct3M_i    = 3'b010;
        aluresultM_i = 32'h100;
        mem_gnt_i    = 1'b1;
        #12;
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_stall", 32'(stallM_o), 32'd0);
        chk("rst_rdata", readdataM_o, 32'd0);
        chk("rst_buserr", 32'(bus_err_o), 32'd0);
        chk("rst_be", 32'(mem_be_o), 32'd0);
        idle_inputs();
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        // Loads, grant in issue cycle
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 0, 32'hDEADBEEF, 4'b1111, 32'd0, 32'hDEADBEEF);
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 0, 32'h80FF0000, 4'b1000, 32'd0, 32'hFFFFFF80);
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 0, 32'h80FF0000, 4'b1000, 32'd0, 32'h00000080);
        run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 0, 32'h80FF0000, 4'b1100, 32'd0, 32'hFFFF80FF);
        run_access(1'b1, 1'b0, 3'b101, 32'h100, 32'd0, 1, 32'h1234F00D, 4'b0011, 32'd0, 32'h0000F00D);
        // Stores: rdata on the response must not leak into readdataM_o
        run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 3, 32'hFFFFFFFF, 4'b1100, 32'hABCDABCD, 32'd0);
        run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000EF, 1, 32'd0, 4'b0010, 32'hEFEFEFEF, 32'd0);
        run_access(1'b0, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 0, 32'd0, 4'b1111, 32'hCAFEF00D, 32'd0);

        // Misaligned / illegal / conflicting accesses
        err_case(1'b1, 1'b0, 3'b010, 32'h101);
        err_case(1'b1, 1'b0, 3'b011, 32'h100);
        err_case(1'b1, 1'b0, 3'b001, 32'h101);
        err_case(1'b0, 1'b1, 3'b010, 32'h102);
        err_case(1'b0, 1'b1, 3'b100, 32'h100);
        err_case(1'b1, 1'b1, 3'b010, 32'h100);

        // Timeout: grant never comes; 1 IDLE + 7 REQ stalled cycles with TIMEOUT_CYCLES=8
        @(posedge clk_i); #1;
        memreadM_i   = 1'b1;
        funct3M_i    = 3'b010;
        aluresultM_i = 32'h300;
        n = 0;
        @(negedge clk_i);
        while (stallM_o && n < 20) begin
            n++;
            @(negedge clk_i);
        end
        chk("to_stall_cycles", 32'(n), 32'd8);
        chk("to_buserr", 32'(bus_err_o), 32'd1);
        chk("to_rdata", readdataM_o, 32'd0);
        chk("to_req", 32'(mem_req_o), 32'd0);
        @(posedge clk_i); #1;
        idle_inputs();
        run_access(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 0, 32'h55AA55AA, 4'b1111, 32'd0, 32'h55AA55AA);
        chk("buserr_sticky", 32'(bus_err_o), 32'd1);

        // Reset while waiting for rvalid
        @(posedge clk_i); #1;
        memreadM_i   = 1'b1;
        funct3M_i    = 3'b010;
        aluresultM_i = 32'h108;
        mem_gnt_i    = 1'b1;
        @(negedge clk_i);
        chk("pre_rst_stall", 32'(stallM_o), 32'd1);
        @(posedge clk_i); #1;
        mem_gnt_i = 1'b0;
        #2;
        rst_i = 1'b0;
        #1;
        chk("midrst_req", 32'(mem_req_o), 32'd0);
        chk("midrst_stall", 32'(stallM_o), 32'd0);
        chk("midrst_rdata", readdataM_o, 32'd0);
        chk("midrst_buserr", 32'(bus_err_o), 32'd0);
        @(posedge clk_i); #1;
        idle_inputs();
        rst_i        = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h12345678;
        @(negedge clk_i);
        chk("late_rv_stall", 32'(stallM_o), 32'd0);
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'd0;
        @(negedge clk_i);
        chk("late_rv_rdata", readdataM_o, 32'd0);
        run_access(1'b1, 1'b0, 3'b010, 32'h10C, 32'd0, 0, 32'h0BADF00D, 4'b1111, 32'd0, 32'h0BADF00D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM-stage data-memory access unit of the 5-stage RISC-V pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns load/store controls into byte-enabled requests on a req/gnt/rvalid data-memory bus and stalls the pipeline until the access completes. It returns sign- or zero-extended load data (readdataM_o) for capture by MEM/WB.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in REQ+WAIT before the access is aborted with bus_err_o (range 2..255)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
memreadM_i  input  1  load in MEM stage
memwriteM_i  input  1  store in MEM stage
funct3M_i  input  3  access size/sign (instr[14:12])
aluresultM_i  input  32  effective byte address
writedataM_i  input  32  store data (rs2)
readdataM_o  output  32  formatted load data to MEM/WB
stallM_o  output  1  freeze PC, IF/ID, ID/EX, EX/MEM and hold MEM/WB input
access_err_o  output  1  misaligned/illegal access, one-cycle pulse
bus_err_o  output  1  sticky timeout flag
mem_req_o  output  1  bus request
mem_we_o  output  1  1=write
mem_addr_o  output  32  word address {aluresultM_i[31:2],2'b00}
mem_be_o  output  4  byte enables
mem_wdata_o  output  32  lane-replicated store data
mem_gnt_i  input  1  request accepted
mem_rvalid_i  input  1  response valid (loads and stores)
mem_rdata_i  input  32  read word

Behaviour:
- Reset (async, rst_i=0): state IDLE, timeout counter 0, load-data register 0, bus_err_o 0. All outputs go 0 immediately. Reset mid-access drops mem_req_o at once; a late rvalid after reset release is ignored in IDLE.
- Access is valid when exactly one of memreadM_i/memwriteM_i is 1, funct3 is legal, and the address is aligned.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other funct3 is illegal.
- Alignment: H needs addr[0]=0. W needs addr[1:0]=00.
- Invalid access (misaligned, illegal, or both read and write set): access_err_o=1 for that cycle, no bus request, stallM_o=0, readdataM_o=0. The pipeline advances.
- No memory op: IDLE, stallM_o=0, readdataM_o=0.
- Byte enables:
  - SB/LB(U): be=4'b0001<<addr[1:0], wdata={4{wd[7:0]}}.
  - SH/LH(U): be=4'b0011<<{addr[1],1'b0}, wdata={2{wd[15:0]}}.
  - W: be=4'b1111, wdata=wd.
- mem_addr_o, mem_be_o, mem_wdata_o and mem_we_o are combinational from inputs. They are stable because the EX/MEM register is frozen while stalled.
- FSM:
  - IDLE: on valid access, mem_req_o=1, stallM_o=1. If mem_gnt_i, go WAIT; else go REQ.
  - REQ: mem_req_o=1, stallM_o=1, hold until mem_gnt_i, then go WAIT.
  - WAIT: mem_req_o=0, stallM_o=1. On mem_rvalid_i, register the formatted load data (0 for stores) and go DONE.
  - DONE: stallM_o=0, readdataM_o=register. The pipeline advances on this edge. Next state IDLE.
- Minimum load/store latency: stall for 2 cycles (IDLE with gnt, WAIT with rvalid), then DONE.
- Load formatting: select byte addr[1:0] or half addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- Timeout: counter clears in IDLE and increments each cycle in REQ/WAIT. When it reaches TIMEOUT_CYCLES-1 without completion: set bus_err_o (sticky until reset), drop the request, go DONE with load data 0.
- gnt and rvalid in the same cycle while in REQ: treated as gnt only. rvalid is expected after gnt.
- mem_gnt_i outside IDLE/REQ and mem_rvalid_i outside WAIT are ignored.

Test Plan:
- LW addr 0x100, gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF -> stallM_o high 2 cycles, DONE readdataM_o=0xDEADBEEF, be=1111, addr=0x100.
- LB addr 0x103, rdata 0x80FF_0000 -> be=1000, readdataM_o=0xFFFFFF80. Same with LBU -> 0x00000080. LH addr 0x102 -> 0xFFFF80FF.
- SH addr 0x202, wd 0x1234ABCD, gnt delayed 3 cycles -> mem_req_o held 4 cycles, we=1, be=1100, wdata=0xABCDABCD, stall released in DONE, readdataM_o=0.
- LW addr 0x101 -> access_err_o=1 for one cycle, mem_req_o=0, stallM_o=0. funct3=011 load -> same response.
- TIMEOUT_CYCLES=8, gnt never asserted -> after 8 stalled cycles bus_err_o=1 (sticky), DONE with readdataM_o=0, stall drops.
- Assert rst_i=0 during WAIT -> mem_req_o/stallM_o/readdataM_o=0 immediately. rvalid after release ignored, FSM in IDLE.
